// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampled UART receiver: parity encodings,
// receiver FSM states, baud rate table and the baud divisor helper.
package uart_rx_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DIV_W      = 20;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  // Baud rate selected by the 3-bit baud_select code.
  function automatic int baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Clocks per 16x sample tick, rounded to nearest.
  function automatic logic [DIV_W-1:0] baud_divisor(input int clk_hz, input logic [2:0] sel);
    int baud;
    baud = baud_rate(sel);
    return DIV_W'((clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud));
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversampling tick generator. The divisor for each baud code is a
// constant folded from CLK_HZ; the counter restarts whenever the receiver
// is idle or the baud code changes so every frame starts phase-aligned.
module uart_rx_tick_gen
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_baud_select,
  input  logic       i_clear,
  output logic       o_tick
);

  logic [DIV_W-1:0] w_div_table [8];
  logic [DIV_W-1:0] w_div_m1;
  logic [DIV_W-1:0] r_cnt;
  logic [2:0]       r_baud_prev;
  logic             w_restart;
  logic             w_wrap;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div
      assign w_div_table[gi] = baud_divisor(CLK_HZ, 3'(gi));
    end
  endgenerate

  assign w_div_m1  = w_div_table[i_baud_select] - DIV_W'(1);
  assign w_restart = i_clear || (i_baud_select != r_baud_prev);
  // >= rather than == so a switch to a shorter divisor can never strand the count
  assign w_wrap    = (r_cnt >= w_div_m1);
  assign o_tick    = w_wrap && !w_restart;

  // Divisor counter with restart on idle / baud change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_baud_prev <= 3'd0;
    end else begin
      r_baud_prev <= i_baud_select;
      if (w_restart || w_wrap) r_cnt <= '0;
      else                     r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with 3-sample majority vote, runtime parity and
// stop-bit selection, and a ready/valid output with overrun pulse.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry first-word
// fall-through output FIFO; otherwise a single holding register is used.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        baud_select,
  input  logic              Rx_EN,
  input  logic              RxD,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic              Rx_READY,
  output logic [DATA_W-1:0] Rx_DATA,
  output logic              Rx_VALID,
  output logic              Rx_PERROR,
  output logic              Rx_FERROR,
  output logic              Rx_OERROR
);

  generate
    if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_rx_param: DATA_W must be 5..9 and FIFO_DEPTH a power of 2 >= 2");
    end
  endgenerate

  rx_state_e         r_state;
  rx_state_e         w_state_next;
  logic [1:0]        r_sync;
  logic              r_rx_prev;
  logic              w_rx;
  logic              w_fall;
  logic              w_tick;
  logic [3:0]        r_sample_cnt;
  logic [3:0]        r_bit_idx;
  logic              r_s7;
  logic              r_s8;
  logic              w_vote;
  logic              w_mid;
  logic              w_bit_end;
  logic [DATA_W-1:0] r_shift;
  logic [1:0]        r_par_mode;
  logic              r_two_stop;
  logic              r_perr;
  logic              r_ferr;
  logic              r_wait_high;
  logic              r_done;
  logic              w_parity_en;
  logic              w_par_expected;
  logic              w_tick_clear;
  logic              w_vote_data;
  logic              w_vote_parity;
  logic              w_vote_stop;
  logic              w_final_stop;
  logic              w_start_frame;
  logic              w_accept;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic              w_out_perr;
  logic              w_out_ferr;
  logic              r_oerror;

  uart_rx_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk          (clk),
    .reset        (reset),
    .i_baud_select(baud_select),
    .i_clear      (w_tick_clear),
    .o_tick       (w_tick)
  );

  assign w_rx      = r_sync[1];
  assign w_fall    = r_rx_prev && !w_rx;
  assign w_mid     = w_tick && (r_sample_cnt == 4'(MID_SAMPLE));
  assign w_bit_end = w_tick && (r_sample_cnt == 4'(OVERSAMPLE - 1));
  // Majority of samples 7, 8 and 9; sample 9 is the live synchronised value.
  assign w_vote    = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

  assign w_parity_en    = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
  assign w_par_expected = (r_par_mode == PAR_ODD) ? ~^r_shift : ^r_shift;
  assign w_start_frame  = (r_state == ST_IDLE) && (w_state_next == ST_START);

  // Two-flop synchroniser plus previous value for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], RxD};
      r_rx_prev <= w_rx;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic; dropping Rx_EN aborts any frame in progress.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (Rx_EN && w_fall && !r_wait_high) w_state_next = ST_START;
      ST_START:  if (w_mid && w_vote) w_state_next = ST_IDLE;
                 else if (w_bit_end) w_state_next = ST_DATA;
      ST_DATA:   if (w_bit_end && (r_bit_idx == 4'(DATA_W - 1)))
                   w_state_next = w_parity_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (w_bit_end) w_state_next = ST_STOP1;
      ST_STOP1:  if (w_mid && !r_two_stop) w_state_next = ST_IDLE;
                 else if (w_bit_end) w_state_next = ST_STOP2;
      ST_STOP2:  if (w_mid) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (!Rx_EN) w_state_next = ST_IDLE;
  end

  // FSM output decode: per-state vote strobes and tick counter clear.
  always_comb begin
    w_tick_clear  = 1'b0;
    w_vote_data   = 1'b0;
    w_vote_parity = 1'b0;
    w_vote_stop   = 1'b0;
    w_final_stop  = 1'b0;
    unique case (r_state)
      ST_IDLE:   w_tick_clear  = 1'b1;
      ST_DATA:   w_vote_data   = w_mid;
      ST_PARITY: w_vote_parity = w_mid;
      ST_STOP1:  begin
                   w_vote_stop  = w_mid;
                   w_final_stop = w_mid && !r_two_stop;
                 end
      ST_STOP2:  begin
                   w_vote_stop  = w_mid;
                   w_final_stop = w_mid;
                 end
      default:   ;
    endcase
    if (!Rx_EN) begin
      w_vote_data   = 1'b0;
      w_vote_parity = 1'b0;
      w_vote_stop   = 1'b0;
      w_final_stop  = 1'b0;
    end
  end

  // Receive datapath: sample counting, majority samples, shift register, error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sample_cnt <= '0;
      r_bit_idx    <= '0;
      r_s7         <= 1'b1;
      r_s8         <= 1'b1;
      r_shift      <= '0;
      r_par_mode   <= 2'b00;
      r_two_stop   <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_wait_high  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_frame) begin
        r_sample_cnt <= '0;
        r_bit_idx    <= '0;
        r_par_mode   <= parity_mode;
        r_two_stop   <= two_stop;
        r_perr       <= 1'b0;
        r_ferr       <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        r_sample_cnt <= '0;
      end else if (w_tick) begin
        r_sample_cnt <= r_sample_cnt + 4'd1;
        if (r_sample_cnt == 4'(MID_SAMPLE - 2)) r_s7 <= w_rx;
        if (r_sample_cnt == 4'(MID_SAMPLE - 1)) r_s8 <= w_rx;
        if ((r_state == ST_DATA) && w_bit_end) r_bit_idx <= r_bit_idx + 4'd1;
      end
      if (w_vote_data)           r_shift <= {w_vote, r_shift[DATA_W-1:1]};
      if (w_vote_parity)         r_perr  <= (w_vote != w_par_expected);
      if (w_vote_stop && !w_vote) r_ferr <= 1'b1;
      if (w_final_stop)          r_done  <= 1'b1;
      // A break leaves the line low; re-arm only after it has been seen high.
      if (w_final_stop && !w_vote && (r_shift == '0)) r_wait_high <= 1'b1;
      else if (w_rx)                                  r_wait_high <= 1'b0;
    end
  end

  assign w_accept = w_out_valid && Rx_READY;

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_W + 2;

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_write;

  assign w_full      = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_write     = r_done && (!w_full || w_accept);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_out_valid = (r_count != '0);
  assign w_out_data  = w_out_valid ? w_head[DATA_W-1:0] : '0;
  assign w_out_ferr  = w_out_valid && w_head[DATA_W];
  assign w_out_perr  = w_out_valid && w_head[DATA_W+1];

  // FIFO storage write: {PERROR, FERROR, DATA}.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= {r_perr, r_ferr, r_shift};
  end

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_oerror <= 1'b0;
    end else begin
      r_oerror <= r_done && !w_write;
      if (w_write)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_accept) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_write && !w_accept)      r_count <= r_count + (PTR_W + 1)'(1);
      else if (!w_write && w_accept) r_count <= r_count - (PTR_W + 1)'(1);
    end
  end
`else
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_perr;
  logic              r_hold_ferr;

  assign w_out_valid = r_hold_valid;
  assign w_out_data  = r_hold_data;
  assign w_out_perr  = r_hold_perr;
  assign w_out_ferr  = r_hold_ferr;

  // Single holding register; a frame completing while it is occupied and not being accepted is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_perr  <= 1'b0;
      r_hold_ferr  <= 1'b0;
      r_oerror     <= 1'b0;
    end else begin
      r_oerror <= 1'b0;
      if (r_done && (!r_hold_valid || w_accept)) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= r_shift;
        r_hold_perr  <= r_perr;
        r_hold_ferr  <= r_ferr;
      end else if (r_done) begin
        r_oerror <= 1'b1;
      end else if (w_accept) begin
        r_hold_valid <= 1'b0;
        r_hold_data  <= '0;
        r_hold_perr  <= 1'b0;
        r_hold_ferr  <= 1'b0;
      end
    end
  end
`endif

  assign Rx_DATA   = w_out_data;
  assign Rx_VALID  = w_out_valid;
  assign Rx_PERROR = w_out_perr;
  assign Rx_FERROR = w_out_ferr;
  assign Rx_OERROR = r_oerror;

endmodule
